// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x32 register file.
// Imported by the storage cell and the register file top.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit register with asynchronous active-low clear
// and a load enable; holds its value when not loaded.
module reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = en_i ? d_i : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile_32x32.sv
// MIPS register file: r0 hardwired to zero, one write port,
// two combinational read ports with optional write forwarding.
module regfile_32x32
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [REG_ADDR_W-1:0] read_addr1,
    input  logic [REG_ADDR_W-1:0] read_addr2,
    output logic [WIDTH-1:0]      read_data1,
    output logic [WIDTH-1:0]      read_data2
);

    logic [WIDTH-1:0]      regs [NUM_REGS];
    logic [NUM_REGS-1:1]   wr_sel;
    logic [WIDTH-1:0]      rd1_raw;
    logic [WIDTH-1:0]      rd2_raw;
    logic                  hit1;
    logic                  hit2;

    assign regs[0] = '0;

    // One-hot write decode; index 0 has no cell, so its writes vanish.
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_reg
        assign wr_sel[k] = write_enable
                         && (write_addr == REG_ADDR_W'(k));

        reg_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en_i (wr_sel[k]),
            .d_i  (write_data),
            .q_o  (regs[k])
        );
    end

    assign rd1_raw = regs[read_addr1];
    assign rd2_raw = regs[read_addr2];

    assign hit1 = BYPASS && write_enable
               && (write_addr != ZERO_REG)
               && (write_addr == read_addr1);
    assign hit2 = BYPASS && write_enable
               && (write_addr != ZERO_REG)
               && (write_addr == read_addr2);

    assign read_data1 = hit1 ? write_data : rd1_raw;
    assign read_data2 = hit2 ? write_data : rd2_raw;

endmodule
